// File: rtl/adder_subtractor_combined_if.sv
// Operand/result bundle for the registered adder/subtractor.
// The master drives operands and mode; the slave returns the registered result and flags.
interface adder_subtractor_combined_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic [WIDTH-1:0] r;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output a,
        output b,
        output m,
        input  r,
        input  cout,
        input  ovf,
        input  zero
    );

    modport slave (
        input  a,
        input  b,
        input  m,
        output r,
        output cout,
        output ovf,
        output zero
    );
endinterface

// File: rtl/adder_subtractor_combined.sv
// Registered ripple-carry adder/subtractor. One chain serves both modes: m=1 inverts b and
// injects a carry-in of 1. Result and flags are registered, so latency is one cycle.
module adder_subtractor_combined #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    adder_subtractor_combined_if.slave   bus
);
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;

    logic [WIDTH-1:0] r_d,    r_q;
    logic             cout_d, cout_q;
    logic             ovf_d,  ovf_q;
    logic             zero_d, zero_q;

    assign c[0] = bus.m;

    // One full-adder stage per bit; the carry ripples from LSB to MSB.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_stage
        assign bx[i]  = bus.b[i] ^ bus.m;
        assign s[i]   = bus.a[i] ^ bx[i] ^ c[i];
        assign c[i+1] = (bus.a[i] & bx[i]) | (bus.a[i] & c[i]) | (bx[i] & c[i]);
    end

    always_comb begin
        r_d    = s;
        cout_d = c[WIDTH];
        ovf_d  = c[WIDTH] ^ c[WIDTH-1];
        zero_d = (s == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.r    = r_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_adder_subtractor_combined.sv
// Self-checking bench: directed vectors, mode toggling, mid-stream reset,
// an exhaustive 4-bit sweep and a random 8-bit sweep against an arithmetic model.
module tb_adder_subtractor_combined;
    logic clk;
    logic rst_n;

    adder_subtractor_combined_if #(.WIDTH(4)) bus4 ();
    adder_subtractor_combined_if #(.WIDTH(8)) bus8 ();

    adder_subtractor_combined #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    adder_subtractor_combined #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        exp_t       e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input int a, input int b, input bit m);
        exp_t e;
        int rng  = 1 << w;
        int half = 1 << (w - 1);
        int full = m ? a - b : a + b;
        int sa   = (a >= half) ? a - rng : a;
        int sb   = (b >= half) ? b - rng : b;
        int sr   = m ? sa - sb : sa + sb;
        e.r    = 32'(full & (rng - 1));
        e.cout = m ? (a >= b) : (full >= rng);
        e.ovf  = (sr < -half) || (sr > half - 1);
        e.zero = ((full & (rng - 1)) == 0);
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] ar, input logic ac,
                         input logic ao, input logic az, input exp_t e);
        checks++;
        if (ar !== e.r || ac !== e.cout || ao !== e.ovf || az !== e.zero) begin
            errors++;
            $display("FAIL %s: got r=%0h cout=%b ovf=%b zero=%b, want r=%0h cout=%b ovf=%b zero=%b",
                     nm, ar, ac, ao, az, e.r, e.cout, e.ovf, e.zero);
        end
    endtask

    task automatic check4(input string nm, input exp_t e);
        check(nm, 32'(bus4.r), bus4.cout, bus4.ovf, bus4.zero, e);
    endtask

    task automatic check8(input string nm, input exp_t e);
        check(nm, 32'(bus8.r), bus8.cout, bus8.ovf, bus8.zero, e);
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic m);
        bus4.a = a;
        bus4.b = b;
        bus4.m = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic c, input logic o, input logic z);
        exp_t e;
        e.r = r; e.cout = c; e.ovf = o; e.zero = z;
        return e;
    endfunction

    vec_t vecs[9];
    exp_t zero_e;
    exp_t e;

    initial begin
        vecs[0] = '{"sub_nb_1",   4'b1001, 4'b1000, 1'b1, mk(32'h1, 1'b1, 1'b0, 1'b0)};
        vecs[1] = '{"sub_nb_2",   4'b1010, 4'b1000, 1'b1, mk(32'h2, 1'b1, 1'b0, 1'b0)};
        vecs[2] = '{"sub_borrow", 4'b1001, 4'b1010, 1'b1, mk(32'hF, 1'b0, 1'b0, 1'b0)};
        vecs[3] = '{"sub_equal",  4'h7,    4'h7,    1'b1, mk(32'h0, 1'b1, 1'b0, 1'b1)};
        vecs[4] = '{"add_carry",  4'b1111, 4'b1110, 1'b0, mk(32'hD, 1'b1, 1'b0, 1'b0)};
        vecs[5] = '{"add_ovf",    4'h7,    4'h1,    1'b0, mk(32'h8, 1'b0, 1'b1, 1'b0)};
        vecs[6] = '{"add_zero",   4'h0,    4'h0,    1'b0, mk(32'h0, 1'b0, 1'b0, 1'b1)};
        vecs[7] = '{"sub_ovf",    4'h8,    4'h1,    1'b1, mk(32'h7, 1'b1, 1'b1, 1'b0)};
        vecs[8] = '{"sub_wrap",   4'h0,    4'h1,    1'b1, mk(32'hF, 1'b0, 1'b0, 1'b0)};
        zero_e  = mk(32'h0, 1'b0, 1'b0, 1'b0);

        // Reset holds outputs at zero even with all-ones operands.
        rst_n = 1'b0;
        drive4(4'hF, 4'hF, 1'b0);
        bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.m = 1'b0;
        tick();
        tick();
        check4("reset4", zero_e);
        check8("reset8", zero_e);
        rst_n = 1'b1;
        tick();
        check4("post_reset", mk(32'hE, 1'b1, 1'b0, 1'b0));

        for (int i = 0; i < 9; i++) begin
            drive4(vecs[i].a, vecs[i].b, vecs[i].m);
            tick();
            check4(vecs[i].name, vecs[i].e);
        end

        // Mode toggles every cycle; inputs also glitch between edges.
        for (int i = 0; i < 40; i++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom);
            rb = 4'($urandom);
            drive4(ra, rb, 1'(i % 2));
            tick();
            e = model(4, int'(ra), int'(rb), 1'(i % 2));
            check4("toggle", e);
            drive4(4'($urandom), 4'($urandom), 1'($urandom));
            #3;
            check4("hold", e);
        end

        // Mid-stream reset discards the in-flight operation.
        drive4(4'h9, 4'h3, 1'b0);
        rst_n = 1'b0;
        tick();
        check4("mid_reset", zero_e);
        drive4(4'h5, 4'h6, 1'b1);
        rst_n = 1'b1;
        tick();
        check4("after_mid_reset", model(4, 5, 6, 1'b1));

        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    drive4(4'(a), 4'(b), 1'(m));
                    tick();
                    check4("sweep4", model(4, a, b, 1'(m)));
                end
            end
        end

        for (int i = 0; i < 300; i++) begin
            int ra, rb;
            bit rm;
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            rm = 1'($urandom);
            bus8.a = 8'(ra);
            bus8.b = 8'(rb);
            bus8.m = rm;
            tick();
            check8("sweep8", model(8, ra, rb, rm));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_subtractor_combined.md
Name: adder_subtractor_combined

Overview:
- Registered N-bit ripple-carry adder/subtractor sharing one adder chain.
- The mode bit m selects the operation: m=0 gives a+b, m=1 gives a-b via two's complement (b XOR m, carry-in = m).
- Used as a small arithmetic primitive in datapath blocks. Results and flags are registered, with one-cycle latency.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- a  input  WIDTH  operand A (unsigned or two's complement; same bits either way).
- b  input  WIDTH  operand B.
- m  input  1  mode: 0 = add, 1 = subtract (a - b).
- r  output  WIDTH  registered result, low WIDTH bits of the sum.
- cout  output  1  registered carry out of MSB stage. Add: unsigned carry. Subtract: 1 = no borrow (a >= b unsigned), 0 = borrow.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  registered flag, 1 when the result is all zeros.

Behaviour:
- Reset:
  - On a rising clk edge with rst_n=0, set r=0, cout=0, ovf=0 and zero=0.
  - Reset takes priority over everything else.
  - Reset asserted mid-stream discards the in-flight result; the first valid result appears one cycle after rst_n returns high.
- Datapath (combinational, evaluated each cycle):
  - bx[i] = b[i] XOR m.
  - c[0] = m.
  - s[i] = a[i] XOR bx[i] XOR c[i].
  - c[i+1] = majority(a[i], bx[i], c[i]).
  - Build as WIDTH full-adder stages, generated by a loop.
- Registration:
  - On each rising edge with rst_n=1, capture r=s, cout=c[WIDTH], ovf=c[WIDTH] XOR c[WIDTH-1], zero=(s==0).
  - Latency is exactly 1 cycle from the input sampling edge to the output update.
  - Throughput is one operation per cycle.
  - Outputs hold between edges; input glitches between edges have no effect.
- Arithmetic rules:
  - Results wrap modulo 2^WIDTH.
  - a-b with a<b (unsigned) yields the two's complement value with cout=0.
  - a-b with a==b yields r=0, cout=1, zero=1.
  - a+b overflowing 2^WIDTH gives cout=1 and r = low bits.
  - ovf is computed identically in both modes; the consumer chooses whether to interpret cout or ovf.
- Mode switching:
  - m is sampled on the same edge as a and b.
  - Changing m between cycles needs no flush or bubble.
- No internal state other than the output registers; no X propagation from reset.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with a=4'hF, b=4'hF, m=0 -> r=0, cout=0, ovf=0, zero=0. Release, then one edge later -> r=4'hE, cout=1, ovf=0, zero=0.
- Subtract, no borrow: a=4'b1001, b=4'b1000, m=1 -> next cycle r=4'b0001, cout=1, ovf=0, zero=0. Then a=4'b1010, b=4'b1000 -> r=4'b0010, cout=1.
- Subtract, borrow: a=4'b1001, b=4'b1010, m=1 -> r=4'b1111, cout=0, ovf=0. Also a=4'h7, b=4'h7, m=1 -> r=0, cout=1, zero=1.
- Add with carry: a=4'b1111, b=4'b1110, m=0 -> r=4'b1101, cout=1, ovf=0. Signed overflow case a=4'h7, b=4'h1, m=0 -> r=4'h8, cout=0, ovf=1.
- Back-to-back mode toggling every cycle with random a/b: each output equals the golden (a ± b) of the previous cycle, with no bubble. Then assert rst_n=0 mid-stream -> outputs go to 0 on that edge.
- Exhaustive sweep for WIDTH=4: all a, b, m (512 vectors) checked against the reference model at 1-cycle lag. Repeat a random sweep with WIDTH=8.
